// File: rtl/cc_cond_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cc_cond_unit_pkg
// Description : Shared y86 constants for the condition-code unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cc_cond_unit_pkg;

  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICMOVXX = 4'h2;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam int OF_BIT = 0;
  localparam int SF_BIT = 1;
  localparam int ZF_BIT = 2;

  // Bit order {ZF,SF,OF}: reset value sets ZF only.
  localparam logic [2:0] CC_RESET_VAL = 3'b100;

endpackage : cc_cond_unit_pkg
`default_nettype wire

// File: rtl/cc_cond_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cc_cond_unit_cond_eval
// Description : Combinational jXX/cmovXX condition evaluation from CC.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_cond_unit_cond_eval
  import cc_cond_unit_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       bad
);

  logic w_zf;
  logic w_lt;

  assign w_zf = cc[ZF_BIT];
  assign w_lt = cc[SF_BIT] ^ cc[OF_BIT];

  always_comb begin
    cnd = 1'b0;
    bad = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = w_lt | w_zf;
      C_L:     cnd = w_lt;
      C_E:     cnd = w_zf;
      C_NE:    cnd = ~w_zf;
      C_GE:    cnd = ~w_lt;
      C_G:     cnd = ~w_lt & ~w_zf;
      default: bad = 1'b1;
    endcase
  end

endmodule : cc_cond_unit_cond_eval
`default_nettype wire

// File: rtl/cc_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : cc_cond_unit
// Description : Condition-code register, condition evaluation and staged Cnd.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_cond_unit
  import cc_cond_unit_pkg::*;
#(
  parameter logic [2:0] CC_RESET     = CC_RESET_VAL,
  parameter logic [3:0] ICODE_OPQ    = IOPQ,
  parameter logic [3:0] ICODE_JXX    = IJXX,
  parameter logic [3:0] ICODE_CMOVXX = ICMOVXX
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  input  logic [2:0] flag,
  input  logic       cc_hold,
  input  logic       m_stall,
  input  logic       m_bubble,
  output logic [2:0] cc,
  output logic       cnd,
  output logic       bad_cond,
  output logic       m_cnd
);

  logic [2:0] r_cc;
  logic       r_m_cnd;
  logic       w_cc_upd;
  logic       w_is_cond;
  logic       w_eval_cnd;
  logic       w_eval_bad;

  assign w_cc_upd  = (icode == ICODE_OPQ) & ~cc_hold;
  assign w_is_cond = (icode == ICODE_JXX) | (icode == ICODE_CMOVXX);

  // Evaluated from the registered CC only; no bypass from the live flags.
  cc_cond_unit_cond_eval u_cond_eval (
    .cc   (r_cc),
    .ifun (ifun),
    .cnd  (w_eval_cnd),
    .bad  (w_eval_bad)
  );

  assign cnd      = w_is_cond & w_eval_cnd;
  assign bad_cond = w_is_cond & w_eval_bad;
  assign cc       = r_cc;
  assign m_cnd    = r_m_cnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= CC_RESET;
    end else if (w_cc_upd) begin
      r_cc <= {flag[ZF_BIT], flag[SF_BIT], flag[OF_BIT]};
    end
  end

  // Bubble takes priority over stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_cnd <= 1'b0;
    end else if (m_bubble) begin
      r_m_cnd <= 1'b0;
    end else if (!m_stall) begin
      r_m_cnd <= cnd;
    end
  end

endmodule : cc_cond_unit
`default_nettype wire

// File: tb/tb_cc_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_cond_unit
// Description : Self-checking bench for cc_cond_unit against a flag-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_cond_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] icode;
  logic [3:0] ifun;
  logic [2:0] flag;
  logic       cc_hold;
  logic       m_stall;
  logic       m_bubble;
  logic [2:0] cc;
  logic       cnd;
  logic       bad_cond;
  logic       m_cnd;

  int checks = 0;
  int errors = 0;

  logic [2:0] mdl_cc;
  logic       mdl_m_cnd;

  cc_cond_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .icode    (icode),
    .ifun     (ifun),
    .flag     (flag),
    .cc_hold  (cc_hold),
    .m_stall  (m_stall),
    .m_bubble (m_bubble),
    .cc       (cc),
    .cnd      (cnd),
    .bad_cond (bad_cond),
    .m_cnd    (m_cnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition truth from the flag meanings: "less" is SF!=OF, "equal" is ZF.
  function automatic logic exp_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                   input logic [2:0] c);
    bit zf;
    bit lt;
    bit [6:0] tbl;
    zf = c[2];
    lt = (c[1] != c[0]);
    if (ic != 4'd2 && ic != 4'd7) return 1'b0;
    if (fn > 4'd6) return 1'b0;
    tbl = {!lt && !zf, !lt, !zf, zf, lt, lt || zf, 1'b1};
    return tbl[fn[2:0]];
  endfunction

  function automatic logic exp_bad(input logic [3:0] ic, input logic [3:0] fn);
    return (ic == 4'd2 || ic == 4'd7) && (fn >= 4'd7);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_cc    <= 3'b100;
      mdl_m_cnd <= 1'b0;
    end else begin
      if (icode == 4'd6 && !cc_hold) mdl_cc <= flag;
      if (m_bubble)      mdl_m_cnd <= 1'b0;
      else if (!m_stall) mdl_m_cnd <= exp_cnd(icode, ifun, mdl_cc);
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("cc", {1'b0, cc}, {1'b0, mdl_cc});
      check("cnd", {3'b0, cnd}, {3'b0, exp_cnd(icode, ifun, mdl_cc)});
      check("bad_cond", {3'b0, bad_cond}, {3'b0, exp_bad(icode, ifun)});
      check("m_cnd", {3'b0, m_cnd}, {3'b0, mdl_m_cnd});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cc(input logic [2:0] f);
    icode = 4'd6; flag = f; cc_hold = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b1; icode = 4'd7; ifun = 4'd3; flag = 3'b000;
    cc_hold = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;

    // Reset asserted mid-cycle with no clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("rst_cc_lit", {1'b0, cc}, 4'h4);
    check("rst_mcnd_lit", {3'b0, m_cnd}, 4'h0);
    check("rst_cnd_e_lit", {3'b0, cnd}, 4'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // OPq with SF=1.
    load_cc(3'b010);
    check("opq_cc_lit", {1'b0, cc}, 4'h2);
    icode = 4'd7; ifun = 4'd2; #1;
    check("l_lit", {3'b0, cnd}, 4'h1);
    ifun = 4'd5; #1;
    check("ge_lit", {3'b0, cnd}, 4'h0);
    ifun = 4'd1; #1;
    check("le_lit", {3'b0, cnd}, 4'h1);
    tick();

    // OPq suppressed by cc_hold: flags discarded.
    icode = 4'd6; flag = 3'b001; cc_hold = 1'b1;
    tick();
    check("hold_cc_lit", {1'b0, cc}, 4'h2);
    cc_hold = 1'b0; icode = 4'd0;
    tick();
    check("hold_no_defer_lit", {1'b0, cc}, 4'h2);

    // Sweep every CC value against every ifun for cmov and for a non-cond icode.
    for (int c = 0; c < 8; c++) begin
      load_cc(c[2:0]);
      for (int f = 0; f < 16; f++) begin
        icode = 4'd2; ifun = f[3:0];
        tick();
      end
      for (int f = 0; f < 16; f++) begin
        icode = 4'd3; ifun = f[3:0];
        tick();
      end
    end

    // Same-edge hazard: m_cnd captures cnd from the old CC.
    load_cc(3'b100);
    icode = 4'd6; flag = 3'b000; ifun = 4'd0;
    tick();
    check("hazard_cc_lit", {1'b0, cc}, 4'h0);
    check("hazard_mcnd_lit", {3'b0, m_cnd}, 4'h0);
    icode = 4'd7; ifun = 4'd4; #1;
    check("ne_lit", {3'b0, cnd}, 4'h1);

    // m_cnd stall / bubble / release.
    m_stall = 1'b1;
    repeat (3) begin
      tick();
      check("stall_mcnd_lit", {3'b0, m_cnd}, 4'h0);
    end
    m_bubble = 1'b1;
    tick();
    check("bubble_mcnd_lit", {3'b0, m_cnd}, 4'h0);
    m_stall = 1'b0; m_bubble = 1'b0;
    tick();
    check("release_mcnd_lit", {3'b0, m_cnd}, 4'h1);

    // Reset mid-operation with an OPq pending.
    icode = 4'd6; flag = 3'b011;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cc_lit", {1'b0, cc}, 4'h4);
    check("midrst_mcnd_lit", {3'b0, m_cnd}, 4'h0);
    icode = 4'd0;
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_cc_lit", {1'b0, cc}, 4'h4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cc_cond_unit
`default_nettype wire
